// File: rtl/ascii_code_streamer.sv
// ascii_code_streamer: 5-bit symbol codes -> ASCII bytes through a byte FIFO; 2-cycle latency, valid/ready out.
// code_ready drops while the FIFO is full; define ASCII_LF_EN to emit an LF after every CR.

module fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_rdy,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  always_comb begin
    do_push  = push_vld && (count_q != FULL);
    do_pop   = pop_rdy && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

module ascii_code_streamer #(
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] INVALID_CHAR = 8'h3F,
  parameter bit         DROP_INVALID = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4:0]                  code_in,
  input  logic                        code_valid,
  output logic                        code_ready,
  output logic [7:0]                  ascii_out,
  output logic                        ascii_valid,
  input  logic                        ascii_ready,
  output logic                        err_invalid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        idle
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef ASCII_LF_EN
    S_LF,
`endif
    S_SEND
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ascii_out_q, ascii_out_d;
  logic       ascii_valid_q, ascii_valid_d;
  logic       err_invalid_q, err_invalid_d;
  logic       code_mapped, accept, push_vld, pop_rdy, xfer, fifo_empty;
  logic [7:0] code_byte, fifo_dat;

  // Each code range is contiguous, so a single offset add maps the whole run.
  always_comb begin
    code_mapped = 1'b1;
    code_byte   = INVALID_CHAR;
    case (code_in) inside
      [5'd1:5'd5]:   code_byte = 8'h30 + {3'b000, code_in};
      [5'd10:5'd14]: code_byte = 8'h57 + {3'b000, code_in};
      [5'd26:5'd30]: code_byte = 8'h27 + {3'b000, code_in};
      5'd17:         code_byte = 8'h2B;
      5'd16:         code_byte = 8'h0D;
      default:       code_mapped = 1'b0;
    endcase
  end

  assign code_ready    = (fifo_count != FIFO_FULL);
  assign accept        = code_valid && code_ready;
  assign push_vld      = accept && (code_mapped || !DROP_INVALID);
  assign err_invalid_d = accept && !code_mapped;
  assign fifo_empty    = (fifo_count == '0);
  assign xfer          = ascii_valid_q && ascii_ready;

  fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (code_byte),
    .pop_rdy  (pop_rdy),
    .pop_dat  (fifo_dat),
    .count    (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    ascii_out_d   = ascii_out_q;
    ascii_valid_d = ascii_valid_q;
    pop_rdy       = 1'b0;
    case (state_q)
      S_IDLE: pop_rdy = !fifo_empty;
      default: begin
        if (xfer) begin
`ifdef ASCII_LF_EN
          if (state_q == S_SEND && ascii_out_q == 8'h0D) begin
            ascii_out_d = 8'h0A;
            state_d     = S_LF;
          end else
`endif
          begin
            pop_rdy       = !fifo_empty;
            ascii_valid_d = 1'b0;
            state_d       = S_IDLE;
          end
        end
      end
    endcase
    // Loading the head byte overrides the drop back to idle so throughput stays 1 byte/clk.
    if (pop_rdy) begin
      ascii_out_d   = fifo_dat;
      ascii_valid_d = 1'b1;
      state_d       = S_SEND;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ascii_out_q   <= 8'h00;
      ascii_valid_q <= 1'b0;
      err_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ascii_out_q   <= ascii_out_d;
      ascii_valid_q <= ascii_valid_d;
      err_invalid_q <= err_invalid_d;
    end
  end

  assign ascii_out   = ascii_out_q;
  assign ascii_valid = ascii_valid_q;
  assign err_invalid = err_invalid_q;
  assign idle        = fifo_empty && !ascii_valid_q && (state_q == S_IDLE);
endmodule
